mont_redc: RTL and testbench

//  Word-serial Montgomery reduction (REDC). It converts a value out of the Montgomery domain:
//    r = a * R^-1 mod n, with R = 2^WIDTH.
//  It is the counterpart of the domain-entry blocks, rtMod (R, R^2 mod n) and modInv (n_prime).
//  It consumes their n / n_prime outputs and returns plain residues to the RSA datapath.

---
 rtl/mont_redc.sv | 73 +++++++
 tb/tb_mont_redc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mont_redc.sv
// mont_redc: word-serial Montgomery reduction, r = a * 2^-WIDTH mod n, go/done handshake.
// One WORD-wide digit is eliminated per RED cycle; a single conditional subtract finishes.
module mont_redc #(
   parameter int WIDTH = 4096,
   parameter int WORD  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] n,
   input  logic [WORD-1:0]  n_prime,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done
);
   localparam int NW = WIDTH / WORD;
   localparam int CW = $clog2(NW + 1);
   localparam logic [CW-1:0] LAST = CW'(NW - 1);
   typedef enum logic [1:0] {IDLE, RED, SUB} state_t;
   state_t state, state_nx;
   logic [WIDTH:0] t;
   logic [WIDTH-1:0] n_q;
   logic [WORD-1:0] np_q;
   logic [CW-1:0] cnt;
   logic [WORD-1:0] m;
   logic [WIDTH+WORD-1:0] mn;
   logic [WIDTH+WORD:0] s;
   logic [WIDTH-1:0] diff;
   logic unused_lo;
   // m is chosen so the low digit of s cancels; only the shifted part is kept
   always_comb begin
      m = t[WORD-1:0] * np_q;
      mn = {{WIDTH{1'b0}}, m} * {{WORD{1'b0}}, n_q};
      s = {{WORD{1'b0}}, t} + {1'b0, mn};
      diff = t[WIDTH-1:0] - n_q;
      state_nx = state == IDLE ? (go ? RED : IDLE) : state == RED ? (cnt == LAST ? SUB : RED) : IDLE;
   end
   assign unused_lo = |s[WORD-1:0];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   // busy stays high through the done cycle and is re-evaluated from go in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t <= '0;
         n_q <= '0;
         np_q <= '0;
         cnt <= '0;
         r <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            busy <= go;
            if (go) begin
               t <= {1'b0, a};
               n_q <= n;
               np_q <= n_prime;
               cnt <= '0;
            end
         end else if (state == RED) begin
            t <= s[WIDTH+WORD:WORD];
            cnt <= cnt + 1'b1;
         end else begin
            r <= (t >= {1'b0, n_q}) ? diff : t[WIDTH-1:0];
            done <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mont_redc.sv
// tb_mont_redc: scoreboard bench for mont_redc at WIDTH=64, WORD=32 against a bit-serial halving model.
module tb_mont_redc;
   localparam int WIDTH = 64;
   localparam int WORD = 32;
   localparam int NW = WIDTH / WORD;
   localparam logic [63:0] N = 64'hFFFFFFFFFFFFFFC5;
   localparam logic [31:0] NP = 32'hA08AD8F3;
   logic clk = 1'b0, rst = 1'b1, go = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] r;
   logic busy, done;
   int checks = 0, failures = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mont_redc #(.WIDTH(WIDTH), .WORD(WORD)) dut (
      .clk(clk), .rst(rst), .go(go), .a(a), .n(N), .n_prime(NP),
      .r(r), .busy(busy), .done(done)
   );

   // a * 2^-64 mod N by 64 modular halvings
   function automatic logic [63:0] model(input logic [63:0] av);
      logic [64:0] x;
      x = {1'b0, av % N};
      for (int i = 0; i < 64; i++) x = x[0] ? (x + {1'b0, N}) >> 1 : x >> 1;
      return x[63:0];
   endfunction

   task automatic issue(input logic [63:0] av, input logic [63:0] ev);
      @(negedge clk);
      a = av;
      go = 1'b1;
      exp_q.push_back(ev);
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = done;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL %s: done never seen within 20 cycles", name);
      end
   endtask

   task automatic test_reset();
      bit ok;
      logic [63:0] e;
      rst = 1'b1;
      @(negedge clk);
      checks += 3;
      if (r !== 64'd0) begin failures++; $display("FAIL reset_r: got %h want 0", r); end
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      issue(64'd59, 64'd1);
      wait_done("pre_reset_op", ok);
      if (ok) begin
         e = exp_q.pop_front();
         checks++;
         if (r !== e) begin failures++; $display("FAIL pre_reset_op: got %h want %h", r, e); end
      end
      issue(64'd118, 64'd2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks += 3;
      if (r !== 64'd0) begin failures++; $display("FAIL midreset_r: got %h want 0", r); end
      if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b want 0", done); end
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      issue(64'd118, 64'd2);
      wait_done("post_reset_op", ok);
      if (ok) begin
         e = exp_q.pop_front();
         checks++;
         if (r !== e) begin failures++; $display("FAIL post_reset_op: got %h want %h", r, e); end
      end
   endtask

   task automatic test_latency();
      int busy_cnt, done_at, done_cnt;
      logic [63:0] e;
      e = '0;
      issue(64'd0, 64'd0);
      busy_cnt = busy ? 1 : 0;
      done_at = -1;
      done_cnt = 0;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = k;
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL latency_r: got %h want %h", r, e); end
         end
      end
      checks += 3;
      if (done_at != NW + 1) begin failures++; $display("FAIL latency_done_at: got %0d want %0d", done_at, NW + 1); end
      if (busy_cnt != NW + 2) begin failures++; $display("FAIL latency_busy_cycles: got %0d want %0d", busy_cnt, NW + 2); end
      if (done_cnt != 1) begin failures++; $display("FAIL latency_done_pulses: got %0d want 1", done_cnt); end
   endtask

   task automatic test_values();
      logic [63:0] vals[8];
      logic [63:0] exps[8];
      logic [63:0] e;
      bit ok;
      vals[0] = 64'd59;   exps[0] = 64'd1;
      vals[1] = 64'd118;  exps[1] = 64'd2;
      vals[2] = 64'd3481; exps[2] = 64'd59;
      vals[3] = 64'hFFFFFFFFFFFFFFFF; exps[3] = model(vals[3]);
      vals[4] = N - 1; exps[4] = model(vals[4]);
      for (int i = 5; i < 8; i++) begin
         vals[i] = {$urandom, $urandom};
         exps[i] = model(vals[i]);
      end
      for (int i = 0; i < 8; i++) begin
         issue(vals[i], exps[i]);
         wait_done("value_op", ok);
         if (ok) begin
            e = exp_q.pop_front();
            checks += 2;
            if (r !== e) begin failures++; $display("FAIL value_%0d: a=%h got %h want %h", i, vals[i], r, e); end
            if (!(r < N)) begin failures++; $display("FAIL value_range_%0d: got %h want below %h", i, r, N); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int done_cnt, last_at, n_done;
      logic [63:0] e, av;
      issue(64'd1234, model(64'd1234));
      go = 1'b1;
      a = 64'd999;
      @(negedge clk);
      go = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (r !== e) begin failures++; $display("FAIL ignored_go_r: got %h want %h", r, e); end
            end
         end
      end
      checks++;
      if (done_cnt != 1) begin failures++; $display("FAIL ignored_go_pulses: got %0d want 1", done_cnt); end
      av = 64'h0123456789ABCDEF;
      @(negedge clk);
      a = av;
      go = 1'b1;
      exp_q.push_back(model(av));
      last_at = -1;
      n_done = 0;
      for (int k = 0; k < 40 && n_done < 4; k++) begin
         @(negedge clk);
         if (done) begin
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin failures++; $display("FAIL b2b_r_%0d: got %h want %h", n_done, r, e); end
            if (last_at >= 0) begin
               checks++;
               if (k - last_at != NW + 2) begin failures++; $display("FAIL b2b_period: got %0d want %0d", k - last_at, NW + 2); end
            end
            last_at = k;
            n_done++;
            if (n_done < 4) begin
               av = av * 64'd6364136223846793005 + 64'd1442695040888963407;
               a = av;
               exp_q.push_back(model(av));
            end else go = 1'b0;
         end
      end
      go = 1'b0;
      checks++;
      if (n_done != 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", n_done); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_values();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
